// File: rtl/hand_pkg.sv
// Shared coordinate types, accumulator init values and FSM states
// for the hand bounding-box detector.
package hand_pkg;
    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_MAX = 11'd2047;
    localparam coord_t MIN_INIT  = COORD_MAX;
    localparam coord_t MAX_INIT  = '0;

    typedef enum logic {
        ACCUM,
        UPDATE
    } state_t;
endpackage

// File: rtl/bbox_accum.sv
// Per-frame min/max coordinate and saturating hit-count accumulator.
module bbox_accum
    import hand_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               hit,
    input  coord_t             x,
    input  coord_t             y,
    output coord_t             min_x,
    output coord_t             min_y,
    output coord_t             max_x,
    output coord_t             max_y,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min_x <= MIN_INIT;
            min_y <= MIN_INIT;
            max_x <= MAX_INIT;
            max_y <= MAX_INIT;
            count <= '0;
        end else if (hit) begin
            if (x < min_x) min_x <= x;
            if (y < min_y) min_y <= y;
            if (x > max_x) max_x <= x;
            if (y > max_y) max_y <= y;
            if (count != '1) count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hand_bbox_detector.sv
// Thresholds the pixel stream, accumulates a per-frame bounding box and
// publishes it at frame end with miss-frame hysteresis on hand_detected.
module hand_bbox_detector
    import hand_pkg::*;
#(
    parameter int THRESH      = 128,
    parameter int MIN_PIXELS  = 64,
    parameter int MISS_FRAMES = 3,
    parameter int COUNT_W     = 16
) (
    input  logic         VGA_CLK,
    input  logic         RST,
    input  logic [7:0]   pixel_in,
    input  logic         pixel_valid,
    input  logic [12:0]  VGA_H_CNT,
    input  logic [12:0]  VGA_V_CNT,
    input  logic         frame_end,
    output logic [10:0]  hand_x,
    output logic [10:0]  hand_y,
    output logic [10:0]  hand_width,
    output logic [10:0]  hand_height,
    output logic         hand_detected,
    output logic         frame_done
);

    localparam int MISS_W = $clog2(MISS_FRAMES + 1);
    localparam logic [MISS_W-1:0]  MISS_V   = MISS_W'(MISS_FRAMES);
    localparam logic [7:0]         THRESH_V = 8'(THRESH);
    localparam logic [COUNT_W-1:0] MIN_V    = COUNT_W'(MIN_PIXELS);

    state_t              state;
    logic [MISS_W-1:0]   miss_cnt;
    logic [MISS_W-1:0]   miss_next;
    logic                hit;
    logic                pass;
    coord_t              min_x, min_y, max_x, max_y;
    logic [COUNT_W-1:0]  count;
    logic [COORD_W:0]    span_x, span_y;
    coord_t              width, height;

    // Range check on the full 13-bit counters before truncation to 11 bits.
    assign hit = (state == ACCUM) && pixel_valid && (pixel_in >= THRESH_V)
               && (VGA_H_CNT < 13'd2048) && (VGA_V_CNT < 13'd2048);

    bbox_accum #(.COUNT_W(COUNT_W)) u_accum (
        .clk   (VGA_CLK),
        .rst   (RST),
        .clear (state == UPDATE),
        .hit   (hit),
        .x     (VGA_H_CNT[10:0]),
        .y     (VGA_V_CNT[10:0]),
        .min_x (min_x),
        .min_y (min_y),
        .max_x (max_x),
        .max_y (max_y),
        .count (count)
    );

    always_comb begin
        span_x    = {1'b0, max_x} - {1'b0, min_x} + 12'd1;
        span_y    = {1'b0, max_y} - {1'b0, min_y} + 12'd1;
        width     = span_x[COORD_W] ? COORD_MAX : span_x[COORD_W-1:0];
        height    = span_y[COORD_W] ? COORD_MAX : span_y[COORD_W-1:0];
        // min <= max guard keeps an empty frame failing even with MIN_PIXELS = 0
        pass      = (count >= MIN_V) && (min_x <= max_x) && (min_y <= max_y);
        miss_next = (miss_cnt >= MISS_V) ? MISS_V : miss_cnt + 1'b1;
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            state         <= ACCUM;
            miss_cnt      <= MISS_V;
            hand_x        <= '0;
            hand_y        <= '0;
            hand_width    <= '0;
            hand_height   <= '0;
            hand_detected <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (frame_end) state <= UPDATE;
                end
                UPDATE: begin
                    state      <= ACCUM;
                    frame_done <= 1'b1;
                    if (pass) begin
                        hand_x        <= min_x;
                        hand_y        <= min_y;
                        hand_width    <= width;
                        hand_height   <= height;
                        miss_cnt      <= '0;
                        hand_detected <= 1'b1;
                    end else begin
                        miss_cnt      <= miss_next;
                        hand_detected <= (miss_next < MISS_V);
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_hand_bbox_detector.sv
// Directed self-checking bench: dut uses MIN_PIXELS=32, dut1 uses MIN_PIXELS=1.
module tb_hand_bbox_detector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pix = '0;
    logic        valid = 1'b0;
    logic [12:0] hcnt = '0;
    logic [12:0] vcnt = '0;
    logic        fend = 1'b0;

    logic [10:0] x0, y0, w0, h0, x1, y1, w1, h1;
    logic        det0, done0, det1, done1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hand_bbox_detector #(.THRESH(128), .MIN_PIXELS(32), .MISS_FRAMES(3), .COUNT_W(16)) dut (
        .VGA_CLK(clk), .RST(rst), .pixel_in(pix), .pixel_valid(valid),
        .VGA_H_CNT(hcnt), .VGA_V_CNT(vcnt), .frame_end(fend),
        .hand_x(x0), .hand_y(y0), .hand_width(w0), .hand_height(h0),
        .hand_detected(det0), .frame_done(done0)
    );

    hand_bbox_detector #(.THRESH(128), .MIN_PIXELS(1), .MISS_FRAMES(3), .COUNT_W(16)) dut1 (
        .VGA_CLK(clk), .RST(rst), .pixel_in(pix), .pixel_valid(valid),
        .VGA_H_CNT(hcnt), .VGA_V_CNT(vcnt), .frame_end(fend),
        .hand_x(x1), .hand_y(y1), .hand_width(w1), .hand_height(h1),
        .hand_detected(det1), .frame_done(done1)
    );

    // Drive one clock of inputs; returns #1 after the sampling edge.
    task automatic drive(input logic v, input logic [7:0] p, input int h, input int vv, input logic fe);
        valid = v;
        pix   = p;
        hcnt  = 13'(h);
        vcnt  = 13'(vv);
        fend  = fe;
        @(posedge clk);
        #1;
        valid = 1'b0;
        fend  = 1'b0;
    endtask

    // frame_end pulse then the UPDATE cycle; returns when frame_done should be high.
    task automatic end_frame();
        drive(1'b0, 8'd0, 0, 0, 1'b1);
        drive(1'b0, 8'd0, 0, 0, 1'b0);
    endtask

    task automatic block_frame();
        for (int yy = 50; yy <= 54; yy++)
            for (int xx = 100; xx <= 109; xx++)
                drive(1'b1, 8'd200, xx, yy, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'd0, 0, 0, 1'b0);
        drive(1'b0, 8'd0, 0, 0, 1'b0);
        total++;
        if ({x0, y0, w0, h0, det0, done0} !== 46'd0) begin
            bad++;
            $display("FAIL reset_dut got=%h,%h,%h,%h,%b,%b exp=all zero", x0, y0, w0, h0, det0, done0);
        end
        total++;
        if ({x1, y1, w1, h1, det1, done1} !== 46'd0) begin
            bad++;
            $display("FAIL reset_dut1 got=%h,%h,%h,%h,%b,%b exp=all zero", x1, y1, w1, h1, det1, done1);
        end
        rst = 1'b0;
    endtask

    task automatic test_block();
        block_frame();
        drive(1'b0, 8'd0, 0, 0, 1'b1);
        total++;
        if (done0 !== 1'b0) begin
            bad++;
            $display("FAIL block_early_done got=%b exp=0", done0);
        end
        drive(1'b0, 8'd0, 0, 0, 1'b0);
        total++;
        if (done0 !== 1'b1) begin
            bad++;
            $display("FAIL block_done got=%b exp=1", done0);
        end
        total++;
        if ({x0, y0, w0, h0, det0} !== {11'd100, 11'd50, 11'd10, 11'd5, 1'b1}) begin
            bad++;
            $display("FAIL block_box got=%0d,%0d,%0d,%0d,%b exp=100,50,10,5,1", x0, y0, w0, h0, det0);
        end
        drive(1'b0, 8'd0, 0, 0, 1'b0);
        total++;
        if (done0 !== 1'b0) begin
            bad++;
            $display("FAIL block_done_pulse got=%b exp=0", done0);
        end
    endtask

    task automatic test_below_min();
        rst = 1'b1;
        drive(1'b0, 8'd0, 0, 0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 31; i++) drive(1'b1, 8'd200, i, 0, 1'b0);
        end_frame();
        total++;
        if ({x0, y0, w0, h0, det0, done0} !== 46'd1) begin
            bad++;
            $display("FAIL below_min got=%0d,%0d,%0d,%0d,%b,%b exp=0,0,0,0,0,1", x0, y0, w0, h0, det0, done0);
        end
    endtask

    task automatic test_miss_hysteresis();
        logic exp_det [3] = '{1'b1, 1'b1, 1'b0};
        block_frame();
        end_frame();
        total++;
        if ({x0, y0, w0, h0, det0} !== {11'd100, 11'd50, 11'd10, 11'd5, 1'b1}) begin
            bad++;
            $display("FAIL miss_pass got=%0d,%0d,%0d,%0d,%b exp=100,50,10,5,1", x0, y0, w0, h0, det0);
        end
        for (int f = 0; f < 3; f++) begin
            drive(1'b0, 8'd0, 0, 0, 1'b0);
            end_frame();
            total++;
            if ({x0, y0, w0, h0, det0, done0} !== {11'd100, 11'd50, 11'd10, 11'd5, exp_det[f], 1'b1}) begin
                bad++;
                $display("FAIL miss_empty%0d got=%0d,%0d,%0d,%0d,%b,%b exp=100,50,10,5,%b,1",
                         f, x0, y0, w0, h0, det0, done0, exp_det[f]);
            end
        end
    endtask

    task automatic test_threshold();
        drive(1'b1, 8'd127, 5, 5, 1'b0);
        drive(1'b1, 8'd128, 9, 7, 1'b0);
        end_frame();
        total++;
        if ({x1, y1, w1, h1, det1, done1} !== {11'd9, 11'd7, 11'd1, 11'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL threshold got=%0d,%0d,%0d,%0d,%b,%b exp=9,7,1,1,1,1", x1, y1, w1, h1, det1, done1);
        end
    endtask

    task automatic test_frame_edges();
        drive(1'b1, 8'd200, 2048, 40, 1'b0);
        drive(1'b1, 8'd200, 10, 2048, 1'b0);
        drive(1'b1, 8'd200, 20, 20, 1'b1);
        drive(1'b1, 8'd200, 30, 30, 1'b0);
        total++;
        if ({x1, y1, w1, h1, det1, done1} !== {11'd20, 11'd20, 11'd1, 11'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL edge_coincident got=%0d,%0d,%0d,%0d,%b,%b exp=20,20,1,1,1,1", x1, y1, w1, h1, det1, done1);
        end
        drive(1'b1, 8'd200, 25, 25, 1'b0);
        end_frame();
        total++;
        if ({x1, y1, w1, h1, det1} !== {11'd25, 11'd25, 11'd1, 11'd1, 1'b1}) begin
            bad++;
            $display("FAIL edge_update_drop got=%0d,%0d,%0d,%0d,%b exp=25,25,1,1,1", x1, y1, w1, h1, det1);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 8'd255, 0, 0, 1'b0);
        drive(1'b1, 8'd255, 2047, 2047, 1'b0);
        end_frame();
        total++;
        if ({x1, y1, w1, h1, det1} !== {11'd0, 11'd0, 11'd2047, 11'd2047, 1'b1}) begin
            bad++;
            $display("FAIL saturation got=%0d,%0d,%0d,%0d,%b exp=0,0,2047,2047,1", x1, y1, w1, h1, det1);
        end
    endtask

    task automatic test_reset_mid_frame();
        block_frame();
        end_frame();
        for (int i = 0; i < 100; i++) drive(1'b1, 8'd200, i, 0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 8'd0, 0, 0, 1'b0);
        total++;
        if ({x0, y0, w0, h0, det0, done0} !== 46'd0) begin
            bad++;
            $display("FAIL midrst_during got=%0d,%0d,%0d,%0d,%b,%b exp=all zero", x0, y0, w0, h0, det0, done0);
        end
        rst = 1'b0;
        for (int i = 300; i < 340; i++) drive(1'b1, 8'd200, i, 10, 1'b0);
        end_frame();
        total++;
        if ({x0, y0, w0, h0, det0, done0} !== {11'd300, 11'd10, 11'd40, 11'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL midrst_after got=%0d,%0d,%0d,%0d,%b,%b exp=300,10,40,1,1,1", x0, y0, w0, h0, det0, done0);
        end
    endtask

    initial begin
        test_reset();
        test_block();
        test_below_min();
        test_miss_hysteresis();
        test_threshold();
        test_frame_edges();
        test_saturation();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hand_bbox_detector.md
Name: hand_bbox_detector

Overview:
- Sits directly upstream of the hand masking stage in the VGA pixel pipeline.
- Thresholds the incoming 8-bit pixel stream and accumulates a per-frame bounding box of above-threshold pixels.
- At each frame end it publishes hand_x/hand_y/hand_width/hand_height/hand_detected.
- A miss-frame hysteresis prevents flicker of hand_detected.

Parameters:
- THRESH, 128: pixel_in >= THRESH counts as a hand pixel.
- MIN_PIXELS, 64: minimum hand-pixel count per frame for a valid detection.
- MISS_FRAMES, 3: consecutive failing frames before hand_detected drops (legal range >= 1).
- COUNT_W, 16: width of the saturating hand-pixel counter.

Ports:
- VGA_CLK  in  1  pixel clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- pixel_in  in  8  pixel intensity/skin score.
- pixel_valid  in  1  high during active video.
- VGA_H_CNT  in  13  horizontal pixel position.
- VGA_V_CNT  in  13  vertical line position.
- frame_end  in  1  one-cycle pulse after the last active pixel of a frame.
- hand_x  out  11  left edge of the box.
- hand_y  out  11  top edge of the box.
- hand_width  out  11  box width.
- hand_height  out  11  box height.
- hand_detected  out  1  box valid.
- frame_done  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset (sync, RST=1 at a VGA_CLK edge):
  - All box outputs = 0, hand_detected = 0, frame_done = 0.
  - miss_cnt = MISS_FRAMES.
  - Accumulators initialised: min_x = min_y = 2047, max_x = max_y = 0, count = 0.
  - state = ACCUM.
- Hit condition: pixel_valid & (pixel_in >= THRESH) & (VGA_H_CNT < 2048) & (VGA_V_CNT < 2048). Coordinates are truncated to 11 bits only after the range check. Out-of-range positions are ignored.
- FSM with two states:
  - ACCUM: on each hit, min_x/min_y/max_x/max_y are updated and count increments, saturating at 2^COUNT_W-1. If frame_end=1, the next state is UPDATE.
  - UPDATE: lasts exactly one cycle, then returns to ACCUM.
- A hit in the same cycle as frame_end is included in the closing frame.
- During the UPDATE cycle, pixels and frame_end are ignored (dropped).
- UPDATE-cycle actions, visible from the following cycle:
  - frame_done = 1 for exactly one cycle; otherwise it is 0.
  - Pass (count >= MIN_PIXELS):
    - hand_x = min_x, hand_y = min_y.
    - hand_width = max_x - min_x + 1, saturated to 2047; hand_height computed the same way.
    - miss_cnt = 0, hand_detected = 1.
  - Fail:
    - miss_cnt_next = min(miss_cnt + 1, MISS_FRAMES).
    - hand_detected = (miss_cnt_next < MISS_FRAMES).
    - Box outputs hold their previous values.
  - Accumulators re-initialised to reset values.
- Latency: frame_end at cycle T -> UPDATE at T+1 -> new outputs and frame_done at T+2.
- Outputs are stable between frame_done pulses; the downstream stage may sample them at any time.
- A frame with zero hits always fails, even when MIN_PIXELS = 0, because the min > max case is guarded.
- Reset mid-frame discards the partial accumulation. The next frame_end reports only post-reset pixels.

Decomposition:
- Shared package hand_pkg:
  - COORD_W = 11.
  - COORD_MAX = 2047.
  - coordinate typedef.
  - Accumulator init constants.
- One natural sub-module, bbox_accum: holds the min/max/count registers with inputs hit, x, y and clear, and outputs min/max/count. hand_bbox_detector owns the FSM, the pass/fail decision, the hysteresis and the output registers.

Test Plan:
1. 10x5 block of pixel_in=200 at x=100..109, y=50..54, MIN_PIXELS=32, then frame_end -> two cycles later: hand_x=100, hand_y=50, hand_width=10, hand_height=5, hand_detected=1, frame_done high for one cycle.
2. After reset, frame with 31 hits (MIN_PIXELS=32) -> hand_detected=0, box outputs 0, frame_done pulses.
3. Passing frame, then three empty frames with MISS_FRAMES=3 -> hand_detected 1, 1, 0 after successive frame_done pulses; box values held throughout.
4. Threshold edge: pixel_in=127 at (5,5) and pixel_in=128 at (9,7) with MIN_PIXELS=1 -> box x=9, y=7, w=1, h=1.
5. Hit at (20,20) coincident with frame_end -> included in the box; hit at (30,30) in the following (UPDATE) cycle -> absent from both this frame and the next; hit at VGA_H_CNT=2048 -> ignored.
6. RST asserted mid-frame after 100 hits, then 40 hits at x=300..339, y=10, MIN_PIXELS=32 -> outputs 0 during reset; after frame_end: hand_x=300, hand_width=40, hand_height=1, hand_detected=1.
